datapath: RTL
=============

# datapath

Sixteen-bit execution datapath of the lab CPU, sitting directly downstream of the instruction-sequencing controller. It holds the eight-entry register file, the A/B/C pipeline registers, the barrel shifter, the ALU and the status register. Every storage element is loaded only under explicit, per-cycle control strobes from the controller. The C register drives the block output and feeds write-back.

## Interface
- No parameters; width fixed at 16 bits, 8 registers.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `readnum` input 3: register file read index (combinational read).
- `writenum` input 3: register file write index.
- `write` input 1: write `data_in` to `R[writenum]` at edge.
- `vsel` input 2: write-back source select.
- `loada` input 1: load A from read port.
- `loadb` input 1: load B from read port.
- `loadc` input 1: load C from ALU result.
- `loads` input 1: load status from ALU flags.
- `asel` input 1: 1 forces the ALU A operand to 0.
- `bsel` input 1: 1 selects `sximm5` as the ALU B operand.
- `shift` input 2: shifter op on B.
- `ALUop` input 2: ALU op.
- `sximm8` input 16: sign-extended 8-bit immediate.
- `sximm5` input 16: sign-extended 5-bit immediate.
- `mdata` input 16: memory read data.
- `PC` input 8: program counter.
- `datapath_out` output 16: contents of C.
- `status` output 3: {Z, N, V}, registered.

## Operation
- `data_in` is selected by `vsel`:
  - 00: C.
  - 01: {8'b0, PC}.
  - 10: `sximm8`.
  - 11: `mdata`.
- Register file:
  - `read_data = R[readnum]` combinationally.
  - At the edge with `write=1`, `R[writenum] <= data_in`.
- A and B each load `read_data` when their strobe is 1; otherwise they hold.
- The shifter acts on B:
  - 00: pass.
  - 01: shift left 1, LSB=0.
  - 10: logical shift right 1, MSB=0.
  - 11: arithmetic shift right 1, MSB replicated.
- ALU operands:
  - `Ain = asel ? 0 : A`.
  - `Bin = bsel ? sximm5 : shifted B`.
- ALU ops (all results mod 2^16):
  - 00: `Ain+Bin`.
  - 01: `Ain-Bin`.
  - 10: `Ain&Bin`.
  - 11: `~Bin`.
- Flags are computed on the ALU result:
  - Z = (result==0).
  - N = result[15].
  - V = signed overflow for ADD/SUB.
    - ADD: operands share a sign and the result sign differs.
    - SUB: operand signs differ and the result sign differs from Ain.
  - V=0 for AND and MVN.
- C and status load independently: `loadc` and `loads` are separate strobes. CMP uses `loads=1` with `loadc=1`.
- Simultaneous events:
  - `loada` and `loadb` in the same cycle: both capture the same `read_data`.
  - `write` with `readnum==writenum` in the same cycle: read returns the old value; the new value is visible from the next cycle.
  - `write` with `vsel=00` and `loadc` in the same cycle: the register receives the pre-edge C.
  - `reset` has priority over every strobe.
- Index values out of range are impossible (3-bit indices); no error behaviour.

## Timing
- Reset (synchronous): R0–R7, A, B, C = 16'h0000; status = 3'b000; `datapath_out` = 0 from the edge at which `reset` is sampled high.
- No state changes between edges. The `datapath_out` and `status` outputs are registered.
- Latency from strobe to visible effect: one edge.
  - MOV immediate: 1 cycle.
  - MOV shifted: 3 cycles (loadb, loadc, write).
  - ADD/AND: 4 cycles (loada, loadb, loadc, write).
  - CMP: 3 cycles (loada, loadb, loadc+loads).
  - MVN: 3 cycles.
- The combinational path `readnum` → `read_data` → A/B D-inputs must settle within one cycle. The controller drives `readnum` in the same cycle as `loada`/`loadb`.
- Reset asserted mid-instruction clears everything at that edge. Partially executed instructions are abandoned with no residual state.

## Test plan
- Reset: hold `reset` 1 cycle after random writes.
  - Response: `datapath_out`=0 and `status`=000.
  - Reading each R via loadb, shift=00, asel=1, ALUop=00, loadc yields 0.
- MOV immediate: `write=1`, `vsel=10`, `writenum=3`, `sximm8=16'hFFF9`.
  - Reading R3 through B→C gives `datapath_out`=16'hFFF9, N=1 (with loads).
- ADD with shift: R0=7, R1=2; sequence loada(R0), loadb(R1), shift=01, ALUop=00, loadc, then write R2 with vsel=00.
  - Response: C=16'h000B, R2=16'h000B.
- CMP flags:
  - 7−7: status=Z1 N0 V0.
  - 16'h8000−1: status=Z0 N0 V1.
  - ADD 16'h7FFF+1: C=16'h8000, status=Z0 N1 V1.
- MVN, AND, ASR:
  - B=16'h00F0, ALUop=11: C=16'hFF0F.
  - A=16'h0FF0 AND B=16'h00FF: C=16'h00F0.
  - B=16'h8004, shift=11, asel=1, ALUop=00: C=16'hC002.
- Simultaneous and edge cases:
  - `write` R4 and `loada` from R4 in the same cycle: A gets the old value.
  - `reset` with `loadc=1` in the same cycle: C=0.
  - `bsel=1`, `sximm5`=16'hFFF0, A=16'h0010, ADD: C=0, Z=1.

Source files
------------

// File: rtl/datapath_if.sv
// Purpose: control strobes, operands and results between the sequencing controller and the datapath.
// Latency: none; wires only.
// Backpressure: none; the controller sequences every transfer with per-cycle strobes.
interface datapath_if;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [15:0] mdata;
    logic [7:0]  PC;
    logic [15:0] datapath_out;
    logic [2:0]  status;

    // Controller side: drives strobes and operands, observes C and the flags.
    modport master (
        output readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, sximm8, sximm5, mdata, PC,
        input  datapath_out, status
    );

    // Datapath side.
    modport slave (
        input  readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, sximm8, sximm5, mdata, PC,
        output datapath_out, status
    );
endinterface

// File: rtl/datapath.sv
// Purpose: 16-bit CPU datapath: 8x16 register file, A/B/C registers, shifter, ALU, {Z,N,V} status.
// Latency: one edge from any strobe to its visible effect; outputs come straight from C and status.
// Backpressure: none; every register loads only when its strobe is high and holds otherwise.
module datapath (
    input  logic       clk,
    input  logic       reset,
    datapath_if.slave  dp
);
    logic [15:0] regs [8];
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] c_q;
    logic [2:0]  status_q;

    logic [15:0] read_data;
    logic [15:0] data_in;
    logic [15:0] b_shift;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [15:0] alu_res;
    logic        v_flag;
    logic [2:0]  flags;

    // Combinational read port; a same-cycle write is not visible until after the edge.
    assign read_data = regs[dp.readnum];

    // Write-back source select; C here is the pre-edge value even if loadc is also set.
    always_comb begin
        data_in = c_q;
        case (dp.vsel)
            2'b00:   data_in = c_q;
            2'b01:   data_in = {8'h00, dp.PC};
            2'b10:   data_in = dp.sximm8;
            default: data_in = dp.mdata;
        endcase
    end

    // Single-position shifter on B.
    always_comb begin
        b_shift = b_q;
        case (dp.shift)
            2'b00:   b_shift = b_q;
            2'b01:   b_shift = {b_q[14:0], 1'b0};
            2'b10:   b_shift = {1'b0, b_q[15:1]};
            default: b_shift = {b_q[15], b_q[15:1]};
        endcase
    end

    assign ain = dp.asel ? 16'h0000 : a_q;
    assign bin = dp.bsel ? dp.sximm5 : b_shift;

    // ALU result and signed overflow; overflow only meaningful for ADD/SUB.
    always_comb begin
        alu_res = 16'h0000;
        v_flag  = 1'b0;
        case (dp.ALUop)
            2'b00: begin
                alu_res = ain + bin;
                v_flag  = (ain[15] == bin[15]) && (alu_res[15] != ain[15]);
            end
            2'b01: begin
                alu_res = ain - bin;
                v_flag  = (ain[15] != bin[15]) && (alu_res[15] != ain[15]);
            end
            2'b10:   alu_res = ain & bin;
            default: alu_res = ~bin;
        endcase
    end

    assign flags = {(alu_res == 16'h0000), alu_res[15], v_flag};

    // All architectural state: reset wins over every strobe, otherwise strobe-gated loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 16'h0000;
            end
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            c_q      <= 16'h0000;
            status_q <= 3'b000;
        end else begin
            if (dp.write) regs[dp.writenum] <= data_in;
            if (dp.loada) a_q      <= read_data;
            if (dp.loadb) b_q      <= read_data;
            if (dp.loadc) c_q      <= alu_res;
            if (dp.loads) status_q <= flags;
        end
    end

    assign dp.datapath_out = c_q;
    assign dp.status       = status_q;
endmodule
